// File: rtl/operand_b_pipe_mux_pkg.sv
// Shared codes for operand-B selection: immediate extension modes,
// default datapath width and the source-index map used by the ID stage.
package operand_b_pipe_mux_pkg;

    localparam int DATA_W_DEFAULT  = 32;
    localparam int NUM_SRC_DEFAULT = 4;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'b00,
        EXT_ZERO = 2'b01,
        EXT_LUI  = 2'b10,
        EXT_RSVD = 2'b11
    } ext_mode_e;

    // Full-width source indices on src_data; index NUM_SRC selects the immediate.
    localparam int SRC_RF    = 0;
    localparam int SRC_EXMEM = 1;
    localparam int SRC_MEMWB = 2;
    localparam int SRC_WBBYP = 3;

endpackage

// File: rtl/operand_b_pipe_mux_imm_extender.sv
// Combinational 16-bit immediate extender: sign, zero or LUI placement.
// The reserved mode yields zero and raises rsvd so the caller can flag the beat.
module imm_extender
    import operand_b_pipe_mux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [15:0]       imm16,
    input  logic [1:0]        ext_mode,
    output logic [DATA_W-1:0] ext_value,
    output logic              rsvd
);

    // Signed views so that widening casts replicate the top bit.
    logic signed [15:0] imm_s;
    logic signed [31:0] lui_s;

    assign imm_s = imm16;
    assign lui_s = {imm16, 16'h0000};

    // Pick the extension for the current mode.
    always_comb begin
        ext_value = '0;
        rsvd      = 1'b0;
        case (ext_mode)
            EXT_SIGN: ext_value = DATA_W'(imm_s);
            EXT_ZERO: ext_value = DATA_W'(imm16);
            EXT_LUI:  ext_value = DATA_W'(lui_s);
            default:  rsvd      = 1'b1;
        endcase
    end

endmodule

// File: rtl/operand_b_pipe_mux.sv
// Registered ALU operand-B selector for the ID/EX boundary.
// Main register M drives the outputs; skid register S absorbs one beat of
// EX backpressure so in_ready is purely registered toward ID.
module operand_b_pipe_mux
    import operand_b_pipe_mux_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int NUM_SRC = NUM_SRC_DEFAULT,
    parameter int SEL_W   = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic [15:0]               imm16,
    input  logic [1:0]                ext_mode,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         b_data,
    output logic                      sel_err
);

    localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(NUM_SRC);

    logic [DATA_W-1:0] ext_value;
    logic              ext_rsvd;

    logic [DATA_W-1:0] beat_data;
    logic              beat_err;

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_err;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_err;
    logic              in_ready_q;

    logic              accept;
    logic              emit;
    logic              s_load;
    logic              s_hold;

    imm_extender #(.DATA_W(DATA_W)) u_imm_extender (
        .imm16     (imm16),
        .ext_mode  (ext_mode),
        .ext_value (ext_value),
        .rsvd      (ext_rsvd)
    );

    // Resolve the incoming beat: a source, the immediate, or an error beat of zero.
    always_comb begin
        beat_data = '0;
        beat_err  = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                beat_data = src_data[i*DATA_W +: DATA_W];
                beat_err  = 1'b0;
            end
        end
        if (sel == SEL_IMM) begin
            beat_data = ext_rsvd ? '0 : ext_value;
            beat_err  = ext_rsvd;
        end
    end

    assign accept = in_valid & in_ready_q;
    assign emit   = m_valid & out_ready;
    // A beat parks in S only when M is full and stuck; S stays full until M drains.
    assign s_load = accept & m_valid & ~emit;
    assign s_hold = s_valid & ~emit;

    // Skid buffer state: reset beats flush, flush beats accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_err      <= 1'b0;
            s_valid    <= 1'b0;
            s_data     <= '0;
            s_err      <= 1'b0;
            in_ready_q <= 1'b0;
        end else if (flush) begin
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            if (accept) begin
                if (!m_valid || emit) begin
                    m_valid <= 1'b1;
                    m_data  <= beat_data;
                    m_err   <= beat_err;
                end else begin
                    s_valid <= 1'b1;
                    s_data  <= beat_data;
                    s_err   <= beat_err;
                end
            end else if (emit) begin
                if (s_valid) begin
                    m_data  <= s_data;
                    m_err   <= s_err;
                    s_valid <= 1'b0;
                end else begin
                    m_valid <= 1'b0;
                end
            end
            in_ready_q <= ~(s_load | s_hold);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid;
    assign b_data    = m_data;
    assign sel_err   = m_err;

endmodule

// File: tb/tb_operand_b_pipe_mux.sv
// Directed bench for operand_b_pipe_mux with NUM_SRC=4, DATA_W=32.
module tb_operand_b_pipe_mux;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [SEL_W-1:0]          sel;
    logic [15:0]               imm16;
    logic [1:0]                ext_mode;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         b_data;
    logic                      sel_err;

    int checks = 0;
    int errors = 0;

    operand_b_pipe_mux #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_data  (src_data),
        .sel       (sel),
        .imm16     (imm16),
        .ext_mode  (ext_mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_data    (b_data),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [2:0] s, input logic [15:0] imm, input logic [1:0] mode);
        in_valid = 1'b1;
        sel      = s;
        imm16    = imm;
        ext_mode = mode;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        sel       = '0;
        imm16     = '0;
        ext_mode  = 2'b00;
        for (int i = 0; i < NUM_SRC; i++)
            src_data[i*DATA_W +: DATA_W] = 32'h1111_1111 * (i + 1);

        // Reset
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_b_data",    b_data,         32'd0);
        chk("rst_sel_err",   32'(sel_err),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        step();
        chk("rel_in_ready",  32'(in_ready),  32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        // Source select
        out_ready = 1'b1;
        beat(3'd2, 16'h0000, 2'b00);
        step();
        chk("sel2_valid", 32'(out_valid), 32'd1);
        chk("sel2_data",  b_data,         32'h3333_3333);
        chk("sel2_err",   32'(sel_err),   32'd0);

        // Immediate modes
        beat(3'd4, 16'h8001, 2'b00);
        step();
        chk("imm_sign", b_data, 32'hFFFF_8001);
        chk("imm_sign_err", 32'(sel_err), 32'd0);
        beat(3'd4, 16'h8001, 2'b01);
        step();
        chk("imm_zero", b_data, 32'h0000_8001);
        beat(3'd4, 16'h8001, 2'b10);
        step();
        chk("imm_lui", b_data, 32'h8001_0000);
        beat(3'd4, 16'h8001, 2'b11);
        step();
        chk("imm_rsvd_data", b_data, 32'd0);
        chk("imm_rsvd_err",  32'(sel_err), 32'd1);
        beat(3'd4, 16'h7ffe, 2'b00);
        step();
        chk("imm_sign_pos", b_data, 32'h0000_7FFE);
        chk("imm_pos_err",  32'(sel_err), 32'd0);

        // Illegal select then legal
        beat(3'd5, 16'h1234, 2'b00);
        step();
        chk("ill_data", b_data, 32'd0);
        chk("ill_err",  32'(sel_err), 32'd1);
        beat(3'd1, 16'h0000, 2'b00);
        step();
        chk("legal_data", b_data, 32'h2222_2222);
        chk("legal_err",  32'(sel_err), 32'd0);

        // Drain
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: A, B, C
        out_ready = 1'b0;
        beat(3'd0, 16'h0000, 2'b00);
        step();
        chk("bp_a_data",  b_data, 32'h1111_1111);
        chk("bp_a_ready", 32'(in_ready), 32'd1);
        beat(3'd3, 16'h0000, 2'b00);
        step();
        chk("bp_a_hold",  b_data, 32'h1111_1111);
        chk("bp_b_ready", 32'(in_ready), 32'd0);
        beat(3'd4, 16'h1234, 2'b01);
        step();
        chk("bp_c_hold",  b_data, 32'h1111_1111);
        chk("bp_c_valid", 32'(out_valid), 32'd1);
        chk("bp_c_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_out_b",      b_data, 32'h4444_4444);
        chk("bp_b_ready_up", 32'(in_ready), 32'd1);
        step();
        chk("bp_out_c",  b_data, 32'h0000_1234);
        chk("bp_c_valid2", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Flush with M and S full, beat D offered
        out_ready = 1'b0;
        beat(3'd0, 16'h0000, 2'b00);
        step();
        beat(3'd1, 16'h0000, 2'b00);
        step();
        chk("fl_full_ready", 32'(in_ready), 32'd0);
        beat(3'd2, 16'h0000, 2'b00);
        flush = 1'b1;
        step();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready),  32'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl_no_d1", 32'(out_valid), 32'd0);
        step();
        chk("fl_no_d2", 32'(out_valid), 32'd0);

        // Flush with M empty: offered beat is dropped
        beat(3'd3, 16'h0000, 2'b00);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_empty_drop", 32'(out_valid), 32'd0);

        // Reset mid-operation beats flush
        out_ready = 1'b0;
        beat(3'd2, 16'h0000, 2'b00);
        step();
        chk("mid_loaded", b_data, 32'h3333_3333);
        rst   = 1'b1;
        flush = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  b_data,         32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd0);
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("mid_rel_ready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
